column_serializer: RTL and testbench
====================================

COLUMN_SERIALIZER -- requirements
Module: column_serializer

Interface
REQ-001 Parameter ELEM_W, default 8, element width in bits.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port in_valid  input  1  packed row offered.
REQ-005 Port in_ready  output  1  block accepts row this cycle.
REQ-006 Port in_row  input  4*ELEM_W  packed row; column c at bits [c*ELEM_W +: ELEM_W].
REQ-007 Port out_valid  output  1  element presented.
REQ-008 Port out_ready  input  1  downstream accepts element.
REQ-009 Port out_data  output  ELEM_W  current element.
REQ-010 Port out_col  output  2  column index of out_data, 0..3.
REQ-011 Port out_last  output  1  high with column 3.

Function
REQ-012 Row accept SHALL occur on an edge where in_valid && in_ready; element transfer on an edge where out_valid && out_ready.
REQ-013 States SHALL be IDLE (no row held) and SHIFT (row being emitted).
REQ-014 IDLE -> SHIFT SHALL occur on row accept; the row is latched, column index cleared to 0.
REQ-015 In SHIFT, out_valid SHALL be 1, out_data SHALL equal latched column out_col, out_last SHALL equal (out_col == 3).
REQ-016 Column index SHALL increment by 1 per transfer, wrapping 3 -> 0; it SHALL hold while out_ready is low.
REQ-017 out_data/out_col/out_last SHALL stay stable while out_valid && !out_ready.
REQ-018 Latency: first element valid the cycle after the accepting edge; columns emitted in order 0,1,2,3.
REQ-019 Transfer of column 3 with no further row pending SHALL return to IDLE; out_valid low next cycle.
REQ-020 In IDLE, out_valid, out_last SHALL be 0; out_col SHALL be 0; out_data SHALL be 0.
REQ-021 in_row SHALL be ignored on cycles without a row accept.

Reset
REQ-022 While reset is high, next state SHALL be IDLE, column index 0, out_valid 0, out_last 0, out_data 0, in_ready 0.
REQ-023 in_ready SHALL be 1 in the first cycle after reset deasserts (IDLE).
REQ-024 Reset mid-row SHALL discard the partial row and any buffered row; no further elements of it are emitted.

Configuration
REQ-025 Macro COLUMN_SERIALIZER_SKID_EN SHALL select a one-row holding buffer.
REQ-026 Without macro: in_ready = (state == IDLE); back-to-back rows cost 5 cycles per row (one IDLE bubble).
REQ-027 With macro: in_ready = !buffer_full; accept in IDLE loads the shift row; accept in SHIFT without concurrent column-3 transfer fills the buffer.
REQ-028 With macro, accept on the same edge as column-3 transfer SHALL load the shift row directly, remain SHIFT, column 0.
REQ-029 With macro, column-3 transfer with buffer full SHALL move buffer into shift row, clear buffer, remain SHIFT, column 0; sustained throughput 4 cycles per row.

Structure
REQ-030 Package column_pkg SHALL hold NCOLS = 4, COL_W = 2 and the IDLE/SHIFT state typedef.
REQ-031 Sub-module col_index_ctr SHALL implement the 2-bit wrapping column index with enable and synchronous clear.

Verification
REQ-032 Reset 2 cycles, release -> in_ready=1, out_valid=0, out_col=0 first cycle after.
REQ-033 Row 0x44332211, out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, out_col 0..3, out_last only on 0x44.
REQ-034 Same row, out_ready low 3 cycles at column 1 -> 0x22/col 1 held stable, then 0x33,0x44 resume.
REQ-035 Two rows 0x44332211, 0x88776655 with in_valid held -> without macro 8 elements over 9 cycles with one out_valid=0 bubble; with macro 8 elements on 8 consecutive cycles.
REQ-036 Reset asserted while out_col=2 -> next cycle out_valid=0, out_col=0; next row restarts at column 0.

Source files
------------

// File: rtl/column_pkg.sv
// Shared types and constants for the column serializer: column count, index width, FSM states.
package column_pkg;

    localparam int NCOLS = 4;
    localparam int COL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/col_index_ctr.sv
// Wrapping column index counter with enable and synchronous clear; clear has priority.
module col_index_ctr
    import column_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [COL_W-1:0] col_o
);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        col_d = col_q;
        if (clr_i) begin
            col_d = '0;
        end else if (en_i) begin
            col_d = col_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign col_o = col_q;

endmodule

// File: rtl/column_serializer.sv
// Serializes a packed 4-column row into elements, column 0 first, over a valid/ready stream.
// Define COLUMN_SERIALIZER_SKID_EN to add a one-row holding buffer for 4-cycle-per-row throughput.
module column_serializer
    import column_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCOLS*ELEM_W-1:0] in_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ELEM_W-1:0]       out_data,
    output logic [COL_W-1:0]        out_col,
    output logic                    out_last
);

    state_e                  state_q;
    logic [NCOLS*ELEM_W-1:0] row_q;
    logic [COL_W-1:0]        col;
    logic                    accept;
    logic                    xfer;
    logic                    last_xfer;
    logic                    col_clr;

`ifdef COLUMN_SERIALIZER_SKID_EN
    logic [NCOLS*ELEM_W-1:0] buf_q;
    logic                    buf_full_q;

    assign in_ready = !reset && !buf_full_q;
`else
    assign in_ready = !reset && (state_q == IDLE);
`endif

    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && out_last;
    assign col_clr   = accept && (state_q == IDLE);

    col_index_ctr u_col_index_ctr (
        .clk   (clk),
        .reset (reset),
        .clr_i (col_clr),
        .en_i  (xfer),
        .col_o (col)
    );

    // The index wraps to 0 on every column-3 transfer, so it already reads 0 whenever IDLE.
    assign out_valid = (state_q == SHIFT);
    assign out_col   = col;
    assign out_last  = out_valid && (col == COL_W'(NCOLS - 1));
    assign out_data  = out_valid ? row_q[int'(col)*ELEM_W +: ELEM_W] : '0;

    // NOTE: row payload registers are not reset; out_data is masked while IDLE so stale contents never escape.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
`ifdef COLUMN_SERIALIZER_SKID_EN
            buf_full_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        row_q   <= in_row;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef COLUMN_SERIALIZER_SKID_EN
                    if (last_xfer) begin
                        if (buf_full_q) begin
                            row_q      <= buf_q;
                            buf_full_q <= 1'b0;
                        end else if (accept) begin
                            row_q <= in_row;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (accept) begin
                        buf_q      <= in_row;
                        buf_full_q <= 1'b1;
                    end
`else
                    if (last_xfer) begin
                        state_q <= IDLE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_serializer.sv
// Directed bench for column_serializer: scoreboard of expected elements filled on row accept, checked on transfer.
module tb_column_serializer;

    localparam int ELEM_W = 8;

    typedef struct packed {
        logic [ELEM_W-1:0] data;
        logic [1:0]        col;
        logic              last;
    } elem_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [4*ELEM_W-1:0] in_row;
    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic [1:0]        out_col;
    logic              out_last;

    elem_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    n_xfer  = 0;
    int    n_acc   = 0;
    int    first_x = -1;
    int    last_x  = -1;

`ifdef COLUMN_SERIALIZER_SKID_EN
    localparam int B2B_SPAN = 8;
`else
    localparam int B2B_SPAN = 9;
`endif

    column_serializer #(.ELEM_W(ELEM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: compare a transfer against the scoreboard, record an accept, advance to the next negedge.
    task automatic tick();
        elem_t got;
        elem_t want;
        #1;
        if (out_valid && out_ready) begin
            got = {out_data, out_col, out_last};
            if (exp_q.size() == 0) begin
                check("unexpected_elem_queue_size", 64'(exp_q.size()), 64'd1);
            end else begin
                want = exp_q.pop_front();
                check("elem", 64'(got), 64'(want));
            end
            n_xfer++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        if (in_valid && in_ready) begin
            n_acc++;
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back({in_row[c*ELEM_W +: ELEM_W], 2'(c), (c == 3)});
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset for two cycles, then release
        tick();
        tick();
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_col", 64'(out_col), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);

        // Single row, downstream always ready; in_row changes afterwards are ignored
        in_row    = 32'h4433_2211;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_row   = 32'hdead_beef;
        for (int i = 0; i < 4; i++) begin
            check("row_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_out_last", 64'(out_last), 64'd0);
        check("idle_out_col", 64'(out_col), 64'd0);
        check("idle_out_data", 64'(out_data), 64'd0);
        check("row_queue_empty", 64'(exp_q.size()), 64'd0);

        // Stall three cycles at column 1
        in_row   = 32'h4433_2211;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        in_row    = 32'hcafe_f00d;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_elem", 64'({out_data, out_col, out_last}), 64'({8'h22, 2'd1, 1'b0}));
            tick();
        end
        out_ready = 1'b1;
        drain(10);

        // Back-to-back rows with in_valid held
        n_xfer  = 0;
        n_acc   = 0;
        first_x = -1;
        last_x  = -1;
        in_row   = 32'h4433_2211;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && n_xfer < 8; i++) begin
            if (n_acc == 1) in_row = 32'h8877_6655;
            if (n_acc >= 2) in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("b2b_elems", 64'(n_xfer), 64'd8);
        check("b2b_span", 64'(last_x - first_x + 1), 64'(B2B_SPAN));
        drain(10);

        // Reset while column 2 is presented
        in_row   = 32'h0403_0201;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_col_before_reset", 64'(out_col), 64'd2);
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        exp_q.delete();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_col", 64'(out_col), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        in_row   = 32'hddcc_bbaa;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("restart_valid", 64'(out_valid), 64'd1);
        check("restart_col", 64'(out_col), 64'd0);
        drain(10);
        check("final_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
